// File: rtl/fpu_pkg.sv
// Shared definitions for the half-precision FPU controllers.
// Covers state encoding, field positions, special constants, OFUF codes and flag indices.
package fpu_pkg;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StClassify = 3'd1;
   localparam logic [2:0] StLaunch   = 3'd2;
   localparam logic [2:0] StWait     = 3'd3;
   localparam logic [2:0] StResp     = 3'd4;

   localparam int unsigned SignBit = 15;
   localparam int unsigned ExpHi   = 14;
   localparam int unsigned ExpLo   = 10;
   localparam int unsigned ManHi   = 9;
   localparam int unsigned ManLo   = 0;

   localparam logic [15:0] QNAN = 16'h7E00;
   localparam logic [15:0] INF  = 16'h7C00;

   localparam logic [1:0] OfufOk  = 2'b00;
   localparam logic [1:0] OfufUf  = 2'b01;
   localparam logic [1:0] OfufOf  = 2'b10;
   localparam logic [1:0] OfufBad = 2'b11;

   localparam int unsigned FlagTimeout   = 4;
   localparam int unsigned FlagInvalid   = 3;
   localparam int unsigned FlagDivzero   = 2;
   localparam int unsigned FlagOverflow  = 1;
   localparam int unsigned FlagUnderflow = 0;

   typedef struct packed {
      logic sign;
      logic zero;
      logic inf;
      logic nan;
      logic sub;
   } half_class_t;

   // Apply a sign to a magnitude constant such as INF or zero.
   function automatic logic [15:0] with_sign(input logic s, input logic [15:0] mag);
      return {s, mag[14:0]};
   endfunction

endpackage

// File: rtl/fpu_half_classify.sv
// Combinational classifier for one half-precision operand.
// Shared by the mul/div and add/sub controllers.
module fpu_half_classify
   import fpu_pkg::*;
(
   input  logic [15:0] x,
   output logic        sign,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_nan,
   output logic        is_sub
);

   logic [4:0] exp_f;
   logic [9:0] man_f;
   logic       exp_max;
   logic       man_nz;

   assign exp_f   = x[ExpHi:ExpLo];
   assign man_f   = x[ManHi:ManLo];
   assign exp_max = (exp_f == 5'h1f);
   assign man_nz  = (man_f != 10'd0);

   assign sign    = x[SignBit];
   assign is_zero = (exp_f == 5'd0) && !man_nz;
   assign is_sub  = (exp_f == 5'd0) && man_nz;
   assign is_inf  = exp_max && !man_nz;
   assign is_nan  = exp_max && man_nz;

endmodule

// File: rtl/fpu_muldiv_ctrl.sv
// Issue/response controller for the half-precision multiply/divide unit.
// Define MULDIV_FTZ_EN to treat subnormal operands as signed zero.
module fpu_muldiv_ctrl
   import fpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_x,
   input  logic [15:0] req_y,
   input  logic        req_div,
   output logic [15:0] md_x,
   output logic [15:0] md_y,
   output logic        md_mulOrDiv,
   output logic        md_reset,
   input  logic        md_done,
   input  logic [15:0] md_result,
   input  logic [1:0]  md_ofuf,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [4:0]  rsp_flags
);

`ifdef MULDIV_FTZ_EN
   localparam logic Ftz = 1'b1;
`else
   localparam logic Ftz = 1'b0;
`endif

   logic [2:0]       state_q, state_d;
   logic [15:0]      md_x_q, md_x_d, md_y_q, md_y_d;
   logic             md_div_q, md_div_d;
   logic             md_reset_q, md_reset_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [15:0]      rsp_result_q, rsp_result_d;
   logic [4:0]       rsp_flags_q, rsp_flags_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

   half_class_t cx, cy;
   logic        s, x_zero, y_zero;
   logic        bypass;
   logic [15:0] byp_result, done_result;
   logic [4:0]  byp_flags, done_flags;

   fpu_half_classify u_class_x (
      .x       (md_x_q),
      .sign    (cx.sign),
      .is_zero (cx.zero),
      .is_inf  (cx.inf),
      .is_nan  (cx.nan),
      .is_sub  (cx.sub)
   );

   fpu_half_classify u_class_y (
      .x       (md_y_q),
      .sign    (cy.sign),
      .is_zero (cy.zero),
      .is_inf  (cy.inf),
      .is_nan  (cy.nan),
      .is_sub  (cy.sub)
   );

   assign s      = cx.sign ^ cy.sign;
   assign x_zero = cx.zero || (Ftz && cx.sub);
   assign y_zero = cy.zero || (Ftz && cy.sub);

   // Special-case resolution; rule order matters (e.g. 0/0 before x/0).
   always_comb begin
      bypass     = 1'b1;
      byp_result = 16'h0000;
      byp_flags  = 5'b0;
      if (cx.nan || cy.nan) begin
         byp_result             = QNAN;
         byp_flags[FlagInvalid] = 1'b1;
      end else if (!md_div_q) begin
         if ((cx.inf && y_zero) || (x_zero && cy.inf)) begin
            byp_result             = QNAN;
            byp_flags[FlagInvalid] = 1'b1;
         end else if (cx.inf || cy.inf) begin
            byp_result = with_sign(s, INF);
         end else if (x_zero || y_zero) begin
            byp_result = with_sign(s, 16'h0000);
         end else begin
            bypass = 1'b0;
         end
      end else begin
         if ((x_zero && y_zero) || (cx.inf && cy.inf)) begin
            byp_result             = QNAN;
            byp_flags[FlagInvalid] = 1'b1;
         end else if (cx.inf) begin
            byp_result = with_sign(s, INF);
         end else if (y_zero) begin
            byp_result             = with_sign(s, INF);
            byp_flags[FlagDivzero] = 1'b1;
         end else if (x_zero || cy.inf) begin
            byp_result = with_sign(s, 16'h0000);
         end else begin
            bypass = 1'b0;
         end
      end
   end

   always_comb begin
      done_result = md_result;
      done_flags  = 5'b0;
      case (md_ofuf)
         OfufOf: begin
            done_result              = with_sign(s, INF);
            done_flags[FlagOverflow] = 1'b1;
         end
         OfufUf: begin
            done_result               = with_sign(s, 16'h0000);
            done_flags[FlagUnderflow] = 1'b1;
         end
         OfufBad: begin
            done_result             = QNAN;
            done_flags[FlagInvalid] = 1'b1;
         end
         default: done_result = md_result;
      endcase
   end

   assign cnt_inc = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d      = state_q;
      md_x_d       = md_x_q;
      md_y_d       = md_y_q;
      md_div_d     = md_div_q;
      md_reset_d   = md_reset_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flags_d  = rsp_flags_q;
      cnt_d        = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               md_x_d   = req_x;
               md_y_d   = req_y;
               md_div_d = req_div;
               state_d  = StClassify;
            end
         end
         StClassify: begin
            if (bypass) begin
               rsp_valid_d  = 1'b1;
               rsp_result_d = byp_result;
               rsp_flags_d  = byp_flags;
               state_d      = StResp;
            end else begin
               md_reset_d = 1'b0;
               cnt_d      = '0;
               state_d    = StLaunch;
            end
         end
         StLaunch: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // A done in the final cycle takes priority over the timeout.
            if (md_done) begin
               md_reset_d   = 1'b1;
               rsp_valid_d  = 1'b1;
               rsp_result_d = done_result;
               rsp_flags_d  = done_flags;
               state_d      = StResp;
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               md_reset_d   = 1'b1;
               rsp_valid_d  = 1'b1;
               rsp_result_d = QNAN;
               rsp_flags_d  = 5'b0;
               rsp_flags_d[FlagTimeout] = 1'b1;
               state_d      = StResp;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         md_x_q       <= 16'h0000;
         md_y_q       <= 16'h0000;
         md_div_q     <= 1'b0;
         md_reset_q   <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 16'h0000;
         rsp_flags_q  <= 5'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         md_x_q       <= md_x_d;
         md_y_q       <= md_y_d;
         md_div_q     <= md_div_d;
         md_reset_q   <= md_reset_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flags_q  <= rsp_flags_d;
         cnt_q        <= cnt_d;
      end
   end

   assign req_ready   = (state_q == StIdle);
   assign md_x        = md_x_q;
   assign md_y        = md_y_q;
   assign md_mulOrDiv = md_div_q;
   assign md_reset    = md_reset_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_result  = rsp_result_q;
   assign rsp_flags   = rsp_flags_q;

endmodule

// File: tb/tb_fpu_muldiv_ctrl.sv
// Self-checking bench for fpu_muldiv_ctrl with a behavioural multD stand-in.
// Honours MULDIV_FTZ_EN for the subnormal vector.
module tb_fpu_muldiv_ctrl;

   localparam int TO = 8;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_div;
   logic [15:0] req_x, req_y;
   logic [15:0] md_x, md_y, md_result;
   logic        md_mulOrDiv, md_reset, md_done;
   logic [1:0]  md_ofuf;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic [4:0]  rsp_flags;

   fpu_muldiv_ctrl #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_div     (req_div),
      .md_x        (md_x),
      .md_y        (md_y),
      .md_mulOrDiv (md_mulOrDiv),
      .md_reset    (md_reset),
      .md_done     (md_done),
      .md_result   (md_result),
      .md_ofuf     (md_ofuf),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_result  (rsp_result),
      .rsp_flags   (rsp_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Unit model: counts cycles out of hold-reset, raises done at u_lat (0 = never).
   int          u_lat;
   int          ucnt;
   logic [15:0] u_res;
   logic [1:0]  u_ofuf;
   always @(posedge clk) ucnt <= (md_reset !== 1'b0) ? 0 : ucnt + 1;
   assign md_done   = (md_reset === 1'b0) && (u_lat != 0) && (ucnt == u_lat);
   assign md_result = u_res;
   assign md_ofuf   = u_ofuf;

   bit saw_launch;
   always @(negedge clk) if (md_reset === 1'b0) saw_launch = 1'b1;

   typedef struct {
      logic [15:0] x;
      logic [15:0] y;
      logic        div;
      int          ulat;
      logic [15:0] ures;
      logic [1:0]  uofuf;
      logic [15:0] er;
      logic [4:0]  ef;
      bit          launch;
      int          hold;
   } vec_t;

   typedef struct {
      logic [15:0] r;
      logic [4:0]  f;
      int          lat;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic div,
                               input int ulat, input logic [15:0] ures, input logic [1:0] uofuf,
                               input logic [15:0] er, input logic [4:0] ef, input bit launch,
                               input int hold);
      vec_t v;
      v.x = x; v.y = y; v.div = div; v.ulat = ulat; v.ures = ures; v.uofuf = uofuf;
      v.er = er; v.ef = ef; v.launch = launch; v.hold = hold;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, req_ready, 1);
      chk({tag, "_md_reset"}, md_reset, 1);
      chk({tag, "_md_xy_op"}, {md_x, md_y, 15'd0, md_mulOrDiv}, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_rsp_data"}, {rsp_flags, rsp_result}, 0);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t        e;
      int          lat;
      logic [15:0] r0;
      logic [4:0]  f0;
      @(negedge clk);
      u_lat = v.ulat; u_res = v.ures; u_ofuf = v.uofuf;
      req_x = v.x; req_y = v.y; req_div = v.div; req_valid = 1'b1;
      saw_launch = 1'b0;
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk);
      e.r = v.er; e.f = v.ef;
      e.lat = v.launch ? 3 + ((v.ulat == 0) ? TO : v.ulat) : 2;
      sb.push_back(e);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("rsp_arrived", rsp_valid, 1);
      e = sb.pop_front();
      chk("rsp_result", rsp_result, e.r);
      chk("rsp_flags", rsp_flags, e.f);
      chk("latency", lat, e.lat);
      chk("launched", saw_launch, v.launch);
      chk("md_reset_in_resp", md_reset, 1);
      chk("md_operands", {md_x, md_y}, {v.x, v.y});
      chk("md_mulOrDiv", md_mulOrDiv, v.div);
      r0 = rsp_result;
      f0 = rsp_flags;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", {rsp_flags, rsp_result}, {f0, r0});
         chk("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("req_ready_back", req_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_x = 16'h0; req_y = 16'h0; req_div = 1'b0;
      rsp_ready = 1'b0; u_lat = 0; u_res = 16'h0; u_ofuf = 2'b00;

      //          x        y        div  ulat res      ofuf   exp      flags     launch hold
      vt.push_back(mk(16'h3C00, 16'h4000, 1'b0, 5, 16'h4000, 2'b00, 16'h4000, 5'b00000, 1, 0));
      vt.push_back(mk(16'h7C00, 16'h0000, 1'b0, 0, 16'h0000, 2'b00, 16'h7E00, 5'b01000, 0, 0));
      vt.push_back(mk(16'hBC00, 16'h0000, 1'b1, 0, 16'h0000, 2'b00, 16'hFC00, 5'b00100, 0, 0));
      vt.push_back(mk(16'h0000, 16'h0000, 1'b1, 0, 16'h0000, 2'b00, 16'h7E00, 5'b01000, 0, 0));
      vt.push_back(mk(16'hC000, 16'h7000, 1'b0, 3, 16'h1234, 2'b10, 16'hFC00, 5'b00010, 1, 0));
      vt.push_back(mk(16'hC000, 16'h7000, 1'b0, 2, 16'h1234, 2'b01, 16'h8000, 5'b00001, 1, 0));
      vt.push_back(mk(16'h3C00, 16'h4000, 1'b0, 0, 16'h0000, 2'b00, 16'h7E00, 5'b10000, 1, 5));
      vt.push_back(mk(16'h3C00, 16'h4000, 1'b0, TO, 16'h5555, 2'b00, 16'h5555, 5'b00000, 1, 0));
      vt.push_back(mk(16'h3C00, 16'h4000, 1'b0, 1, 16'h1111, 2'b11, 16'h7E00, 5'b01000, 1, 0));
      vt.push_back(mk(16'h4000, 16'h3C00, 1'b1, 4, 16'h4000, 2'b00, 16'h4000, 5'b00000, 1, 1));
      vt.push_back(mk(16'h7E01, 16'h3C00, 1'b0, 0, 16'h0000, 2'b00, 16'h7E00, 5'b01000, 0, 0));
      vt.push_back(mk(16'h7C00, 16'h4000, 1'b1, 0, 16'h0000, 2'b00, 16'h7C00, 5'b00000, 0, 0));
      vt.push_back(mk(16'h3C00, 16'h7C00, 1'b1, 0, 16'h0000, 2'b00, 16'h0000, 5'b00000, 0, 0));
      vt.push_back(mk(16'h8000, 16'h4000, 1'b1, 0, 16'h0000, 2'b00, 16'h8000, 5'b00000, 0, 0));
      vt.push_back(mk(16'h7C00, 16'hC000, 1'b0, 0, 16'h0000, 2'b00, 16'hFC00, 5'b00000, 0, 0));
      vt.push_back(mk(16'h7C00, 16'hFC00, 1'b1, 0, 16'h0000, 2'b00, 16'h7E00, 5'b01000, 0, 0));
      vt.push_back(mk(16'h8000, 16'h3C00, 1'b0, 0, 16'h0000, 2'b00, 16'h8000, 5'b00000, 0, 0));
`ifdef MULDIV_FTZ_EN
      vt.push_back(mk(16'h0001, 16'h3C00, 1'b0, 0, 16'h0000, 2'b00, 16'h0000, 5'b00000, 0, 0));
`else
      vt.push_back(mk(16'h0001, 16'h3C00, 1'b0, 2, 16'h1234, 2'b00, 16'h1234, 5'b00000, 1, 0));
`endif

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vt[i]) run_vec(vt[i]);

      // Asynchronous reset in the middle of WAIT.
      @(negedge clk);
      u_lat = 0;
      req_x = 16'h3C00; req_y = 16'h4000; req_div = 1'b0; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("midwait_launched", md_reset, 0);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_rsp", rsp_valid, 0);
      end
      rst_n = 1'b1;
      run_vec(mk(16'h3C00, 16'h4000, 1'b0, 5, 16'h4000, 2'b00, 16'h4000, 5'b00000, 1, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
